// File: rtl/main_control_fsm_pkg.sv
// main_control_fsm_pkg: state codes, opcode/funct constants and control encodings for the multicycle control FSM.
package main_control_fsm_pkg;
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECUTE  = 4'd6,
    S_ALUWB    = 4'd7,
    S_BRANCH   = 4'd8,
    S_ADDIEXEC = 4'd9,
    S_ADDIWB   = 4'd10
  } state_t;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] F_ADD = 6'b100000;
  localparam logic [5:0] F_SUB = 6'b100010;
  localparam logic [5:0] F_AND = 6'b100100;
  localparam logic [5:0] F_OR  = 6'b100101;
  localparam logic [5:0] F_SLT = 6'b101010;
  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b110;
  localparam logic [2:0] ALU_SLT = 3'b111;
  localparam logic [1:0] AOP_ADD   = 2'b00;
  localparam logic [1:0] AOP_SUB   = 2'b01;
  localparam logic [1:0] AOP_FUNCT = 2'b10;
  localparam logic [1:0] SRCA_PC  = 2'd0;
  localparam logic [1:0] SRCA_REG = 2'd1;
  localparam logic [1:0] SRCB_REG    = 2'd0;
  localparam logic [1:0] SRCB_FOUR   = 2'd1;
  localparam logic [1:0] SRCB_IMM    = 2'd2;
  localparam logic [1:0] SRCB_IMMSH2 = 2'd3;
  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       pc_src;
    logic       reg_write;
    logic       mem_to_reg;
    logic       reg_dst;
    logic       iord;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic       alu_en;
    logic [1:0] alu_op;
  } ctrl_t;
endpackage

// File: rtl/main_control_fsm_alu_decoder.sv
// alu_decoder: maps ALU_op and Funct to the ALU_control code.
module alu_decoder
  import main_control_fsm_pkg::*;
(
  input  logic [1:0] ALU_op,
  input  logic [5:0] Funct,
  output logic [2:0] ALU_control
);
  logic [2:0] funct_code;
  always_comb begin
    funct_code = Funct == F_SUB ? ALU_SUB :
                 Funct == F_AND ? ALU_AND :
                 Funct == F_OR  ? ALU_OR  :
                 Funct == F_SLT ? ALU_SLT : ALU_ADD;
    ALU_control = ALU_op == AOP_SUB   ? ALU_SUB :
                  ALU_op == AOP_FUNCT ? funct_code : ALU_ADD;
  end
endmodule

// File: rtl/main_control_fsm.sv
// main_control_fsm: Moore control FSM for a multicycle MIPS-style datapath.
module main_control_fsm
  import main_control_fsm_pkg::*;
(
  input  logic       Clock,
  input  logic       Reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  output logic       PC_write,
  output logic       Branch,
  output logic       PC_src,
  output logic       Reg_write,
  output logic       Mem_to_reg,
  output logic       Reg_dst,
  output logic       IorD,
  output logic       Mem_write,
  output logic       IR_write,
  output logic [1:0] ALU_src_a,
  output logic [1:0] ALU_src_b,
  output logic [2:0] ALU_control,
  output logic [3:0] State
);
  state_t state, next_state;
  ctrl_t ctrl, ctrl_q;
  logic [2:0] alu_dec;
  always_ff @(posedge Clock)
    state <= Reset ? S_FETCH : next_state;
  always_comb begin
    next_state = S_FETCH;
    case (state)
      S_FETCH:    next_state = S_DECODE;
      S_DECODE:   next_state = (Opcode == OP_LW || Opcode == OP_SW) ? S_MEMADR :
                               Opcode == OP_RTYPE ? S_EXECUTE :
                               Opcode == OP_BEQ   ? S_BRANCH  :
                               Opcode == OP_ADDI  ? S_ADDIEXEC : S_FETCH;
      S_MEMADR:   next_state = Opcode == OP_LW ? S_MEMREAD : S_MEMWRITE;
      S_MEMREAD:  next_state = S_MEMWB;
      S_EXECUTE:  next_state = S_ALUWB;
      S_ADDIEXEC: next_state = S_ADDIWB;
      default:    next_state = S_FETCH;
    endcase
  end
  always_comb begin
    ctrl = '0;
    case (state)
      S_FETCH: begin
        ctrl.ir_write = 1'b1;
        ctrl.pc_write = 1'b1;
        ctrl.alu_src_b = SRCB_FOUR;
        ctrl.alu_en = 1'b1;
      end
      S_DECODE: begin
        ctrl.alu_src_b = SRCB_IMMSH2;
        ctrl.alu_en = 1'b1;
      end
      S_MEMADR, S_ADDIEXEC: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_src_b = SRCB_IMM;
        ctrl.alu_en = 1'b1;
      end
      S_MEMREAD: ctrl.iord = 1'b1;
      S_MEMWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.mem_to_reg = 1'b1;
      end
      S_MEMWRITE: begin
        ctrl.iord = 1'b1;
        ctrl.mem_write = 1'b1;
      end
      S_EXECUTE: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.alu_en = 1'b1;
        ctrl.alu_op = AOP_FUNCT;
      end
      S_ALUWB: begin
        ctrl.reg_write = 1'b1;
        ctrl.reg_dst = 1'b1;
      end
      S_BRANCH: begin
        ctrl.alu_src_a = SRCA_REG;
        ctrl.branch = 1'b1;
        ctrl.pc_src = 1'b1;
        ctrl.alu_en = 1'b1;
        ctrl.alu_op = AOP_SUB;
      end
      S_ADDIWB: ctrl.reg_write = 1'b1;
      default: ctrl = '0;
    endcase
  end
  alu_decoder u_alu_decoder (
    .ALU_op      (ctrl.alu_op),
    .Funct       (Funct),
    .ALU_control (alu_dec)
  );
  // Reset masks outputs combinationally so a write in flight is killed in the same cycle.
  assign ctrl_q = Reset ? '0 : ctrl;
  assign PC_write = ctrl_q.pc_write;
  assign Branch = ctrl_q.branch;
  assign PC_src = ctrl_q.pc_src;
  assign Reg_write = ctrl_q.reg_write;
  assign Mem_to_reg = ctrl_q.mem_to_reg;
  assign Reg_dst = ctrl_q.reg_dst;
  assign IorD = ctrl_q.iord;
  assign Mem_write = ctrl_q.mem_write;
  assign IR_write = ctrl_q.ir_write;
  assign ALU_src_a = ctrl_q.alu_src_a;
  assign ALU_src_b = ctrl_q.alu_src_b;
  assign ALU_control = ctrl_q.alu_en ? alu_dec : 3'b000;
  assign State = Reset ? 4'd0 : state;
endmodule

// File: tb/tb_main_control_fsm.sv
// tb_main_control_fsm: directed table-driven check of the control FSM plus latency sequences.
module tb_main_control_fsm;
  logic clk = 1'b0;
  logic Reset, PC_write, Branch, PC_src, Reg_write, Mem_to_reg, Reg_dst, IorD, Mem_write, IR_write;
  logic [5:0] Opcode, Funct;
  logic [1:0] ALU_src_a, ALU_src_b;
  logic [2:0] ALU_control;
  logic [3:0] State;
  int checks = 0;
  int failures = 0;
  always #5 clk = ~clk;
  main_control_fsm dut (
    .Clock(clk), .Reset(Reset), .Opcode(Opcode), .Funct(Funct),
    .PC_write(PC_write), .Branch(Branch), .PC_src(PC_src), .Reg_write(Reg_write),
    .Mem_to_reg(Mem_to_reg), .Reg_dst(Reg_dst), .IorD(IorD), .Mem_write(Mem_write),
    .IR_write(IR_write), .ALU_src_a(ALU_src_a), .ALU_src_b(ALU_src_b),
    .ALU_control(ALU_control), .State(State)
  );
  typedef struct {
    logic        rst;
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [19:0] exp;
    string       name;
  } vec_t;
  vec_t vecs[$];
  localparam logic [5:0] LW = 6'b100011, SW = 6'b101011, RT = 6'b000000;
  localparam logic [5:0] BEQ = 6'b000100, ADDI = 6'b001000, BAD = 6'b111111;
  // {PC_write,Branch,PC_src,Reg_write,Mem_to_reg,Reg_dst,IorD,Mem_write,IR_write,src_a,src_b,alu,state}
  localparam logic [19:0] E_RST   = 20'd0;
  localparam logic [19:0] E_FETCH = {9'b100000001, 2'd0, 2'd1, 3'b010, 4'd0};
  localparam logic [19:0] E_DEC   = {9'b000000000, 2'd0, 2'd3, 3'b010, 4'd1};
  localparam logic [19:0] E_MADR  = {9'b000000000, 2'd1, 2'd2, 3'b010, 4'd2};
  localparam logic [19:0] E_MRD   = {9'b000000100, 2'd0, 2'd0, 3'b000, 4'd3};
  localparam logic [19:0] E_MWB   = {9'b000110000, 2'd0, 2'd0, 3'b000, 4'd4};
  localparam logic [19:0] E_MWR   = {9'b000000110, 2'd0, 2'd0, 3'b000, 4'd5};
  localparam logic [19:0] E_AWB   = {9'b000101000, 2'd0, 2'd0, 3'b000, 4'd7};
  localparam logic [19:0] E_BR    = {9'b011000000, 2'd1, 2'd0, 3'b110, 4'd8};
  localparam logic [19:0] E_AEX   = {9'b000000000, 2'd1, 2'd2, 3'b010, 4'd9};
  localparam logic [19:0] E_AIWB  = {9'b000100000, 2'd0, 2'd0, 3'b000, 4'd10};
  function automatic logic [19:0] e_exec(input logic [2:0] alu);
    return {9'b000000000, 2'd1, 2'd0, alu, 4'd6};
  endfunction
  task automatic add(input logic rst, input logic [5:0] op, input logic [5:0] fn,
                     input logic [19:0] exp, input string name);
    vec_t v;
    v.rst = rst; v.op = op; v.fn = fn; v.exp = exp; v.name = name;
    vecs.push_back(v);
  endtask
  task automatic add_rtype(input logic [5:0] fn, input logic [2:0] alu, input string name);
    add(0, RT, 6'b000000, E_FETCH, {name, "_fetch"});
    add(0, RT, fn, E_DEC, {name, "_decode"});
    add(0, RT, fn, e_exec(alu), {name, "_execute"});
    add(0, BAD, 6'b111111, E_AWB, {name, "_aluwb"});
  endtask
  task automatic latency(input logic [5:0] op, input int exp, input string name);
    int n = 0;
    Opcode = op;
    Funct = 6'b100000;
    do begin
      @(posedge clk); #1;
      n++;
    end while (State != 4'd0 && n < 20);
    checks++;
    if (n != exp) begin
      failures++;
      $display("FAIL %s: latency got %0d cycles, want %0d", name, n, exp);
    end
  endtask
  logic [19:0] act;
  initial begin
    Reset = 1'b1; Opcode = 6'd0; Funct = 6'd0;
    add(1, LW, 6'd0, E_RST, "reset0");
    add(1, SW, 6'd0, E_RST, "reset1");
    add(0, ADDI, 6'd0, E_FETCH, "addi_fetch");
    add(0, ADDI, 6'd0, E_DEC, "addi_decode");
    add(0, BAD, 6'd0, E_AEX, "addi_exec");
    add(0, LW, 6'd0, E_AIWB, "addi_wb");
    add_rtype(6'b100010, 3'b110, "sub");
    add_rtype(6'b100000, 3'b010, "add");
    add_rtype(6'b100100, 3'b000, "and");
    add_rtype(6'b100101, 3'b001, "or");
    add_rtype(6'b101010, 3'b111, "slt");
    add_rtype(6'b111000, 3'b010, "funct_other");
    add(0, LW, 6'd0, E_FETCH, "lw_fetch");
    add(0, LW, 6'd0, E_DEC, "lw_decode");
    add(0, LW, 6'd0, E_MADR, "lw_memadr");
    add(0, SW, 6'd0, E_MRD, "lw_memread");
    add(0, BEQ, 6'd0, E_MWB, "lw_memwb");
    add(0, SW, 6'd0, E_FETCH, "sw_fetch");
    add(0, SW, 6'd0, E_DEC, "sw_decode");
    add(0, SW, 6'd0, E_MADR, "sw_memadr");
    add(0, LW, 6'd0, E_MWR, "sw_memwrite");
    add(0, BEQ, 6'd0, E_FETCH, "beq_fetch");
    add(0, BEQ, 6'd0, E_DEC, "beq_decode");
    add(0, RT, 6'd0, E_BR, "beq_branch");
    add(0, BAD, 6'd0, E_FETCH, "bad_fetch");
    add(0, BAD, 6'd0, E_DEC, "bad_decode");
    add(0, SW, 6'd0, E_FETCH, "bad_next_fetch");
    add(0, SW, 6'd0, E_DEC, "rstmw_decode");
    add(0, SW, 6'd0, E_MADR, "rstmw_memadr");
    add(1, SW, 6'd0, E_RST, "rstmw_memwrite");
    add(0, RT, 6'd0, E_FETCH, "rstmw_fetch");
    add(0, RT, 6'b100000, E_DEC, "rstaw_decode");
    add(0, RT, 6'b100000, e_exec(3'b010), "rstaw_execute");
    add(1, RT, 6'b100000, E_RST, "rstaw_aluwb");
    add(0, ADDI, 6'd0, E_FETCH, "rstaw_fetch");
    add(1, ADDI, 6'd0, E_RST, "rst_decode");
    add(0, ADDI, 6'd0, E_FETCH, "post_rst_fetch");
    @(posedge clk); #1;
    foreach (vecs[i]) begin
      Reset = vecs[i].rst; Opcode = vecs[i].op; Funct = vecs[i].fn;
      @(negedge clk);
      act = {PC_write, Branch, PC_src, Reg_write, Mem_to_reg, Reg_dst, IorD, Mem_write,
             IR_write, ALU_src_a, ALU_src_b, ALU_control, State};
      checks++;
      if (act !== vecs[i].exp) begin
        failures++;
        $display("FAIL %s: outputs got %b, want %b", vecs[i].name, act, vecs[i].exp);
      end
      checks++;
      if (!$onehot0({PC_write, Branch, Mem_write, Reg_write})) begin
        failures++;
        $display("FAIL %s_exclusive: writes got %b, want at most one high", vecs[i].name,
                 {PC_write, Branch, Mem_write, Reg_write});
      end
      @(posedge clk); #1;
    end
    Reset = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    latency(LW, 5, "lat_lw");
    latency(SW, 4, "lat_sw");
    latency(RT, 4, "lat_rtype");
    latency(ADDI, 4, "lat_addi");
    latency(BEQ, 3, "lat_beq");
    latency(BAD, 2, "lat_unknown");
    latency(6'b010101, 2, "lat_unknown2");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
